// File: rtl/pe_shift_sched.sv
// Round-robin scheduler sharing one bundled-data Pe_Shift PE among NUM_REQ requesters.
// Optional saturating statistics outputs are compiled in with `define PE_SCHED_STATS_EN.
module pe_shift_sched #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 64,
  parameter int DRIVE_CYC   = 2,
  parameter int TIMEOUT_CYC = 255,
  parameter int PE_RST_CYC  = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  input  logic                      rsp_ready,
  output logic                      busy,
  output logic                      pe_rst,
  output logic                      pe_i_drive,
  output logic [DATA_W-1:0]         pe_i_data,
  input  logic                      pe_o_free,
  input  logic                      pe_o_drive,
  input  logic [DATA_W-1:0]         pe_o_data,
  output logic                      pe_i_free,
`ifdef PE_SCHED_STATS_EN
  output logic [31:0]               stat_ops,
  output logic [15:0]               stat_timeouts,
  output logic [15:0]               stat_spurious,
`endif
  output logic [2:0]                dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + PE_RST_CYC + DRIVE_CYC + 1);

  typedef enum logic [2:0] {
    ST_PE_RST = 3'd0,
    ST_IDLE   = 3'd1,
    ST_GRANT  = 3'd2,
    ST_SETUP  = 3'd3,
    ST_DRIVE  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_RESP   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                rst_after_q, rst_after_d;
  logic                busy_q;
  logic                free_s1_q, free_s2_q;
  logic                drv_s1_q, drv_s2_q, drv_s3_q;
  logic                drive_evt;
  logic                timeout_hit;
  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W:0]       cand;

  // PE handshake lines are asynchronous; result data is bundled and only read once drive is synced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_s1_q <= 1'b0;
      free_s2_q <= 1'b0;
      drv_s1_q  <= 1'b0;
      drv_s2_q  <= 1'b0;
      drv_s3_q  <= 1'b0;
    end else begin
      free_s1_q <= pe_o_free;
      free_s2_q <= free_s1_q;
      drv_s1_q  <= pe_o_drive;
      drv_s2_q  <= drv_s1_q;
      drv_s3_q  <= drv_s2_q;
    end
  end

  assign drive_evt   = drv_s2_q & ~drv_s3_q;
  assign timeout_hit = (state_q == ST_WAIT) && !drive_evt && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // First valid requester at or after the rr pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!win_found && req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    id_d        = id_q;
    op_d        = op_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rst_after_d = rst_after_q;
    req_ready   = '0;
    case (state_q)
      ST_PE_RST: begin
        if (cnt_q == CNT_W'(PE_RST_CYC - 1)) state_d = ST_IDLE;
        else                                 cnt_d   = cnt_q + 1'b1;
      end
      ST_IDLE: begin
        if ((|req_valid) && free_s2_q) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        // A requester that withdrew since IDLE leaves nobody to grant.
        if (win_found) begin
          req_ready[win_id] = 1'b1;
          op_d              = req_data[win_id*DATA_W +: DATA_W];
          id_d              = win_id;
          rr_d              = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
          state_d           = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: state_d = ST_DRIVE;
      ST_DRIVE: begin
        if (cnt_q == CNT_W'(DRIVE_CYC - 1)) state_d = ST_WAIT;
        else                                cnt_d   = cnt_q + 1'b1;
      end
      ST_WAIT: begin
        if (drive_evt) begin
          rdata_d     = pe_o_data;
          err_d       = 1'b0;
          rst_after_d = 1'b0;
          state_d     = ST_RESP;
        end else if (timeout_hit) begin
          rdata_d     = '0;
          err_d       = 1'b1;
          rst_after_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = rst_after_q ? ST_PE_RST : ST_IDLE;
          rst_after_d = 1'b0;
        end
      end
      default: state_d = ST_PE_RST;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PE_RST;
      cnt_q       <= '0;
      rr_q        <= '0;
      id_q        <= '0;
      op_q        <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rst_after_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rst_after_q <= rst_after_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign pe_rst      = (state_q == ST_PE_RST);
  assign rsp_valid   = (state_q == ST_RESP);
  assign pe_i_drive  = (state_q == ST_DRIVE);
  assign pe_i_free   = (state_q != ST_RESP) && (state_q != ST_PE_RST);
  assign busy        = busy_q;
  assign rsp_id      = id_q;
  assign rsp_data    = rdata_q;
  assign rsp_err     = err_q;
  assign pe_i_data   = op_q;
  assign dbg_state_o = state_q;

`ifdef PE_SCHED_STATS_EN
  logic [31:0] ops_q;
  logic [15:0] timeouts_q, spurious_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q      <= '0;
      timeouts_q <= '0;
      spurious_q <= '0;
    end else begin
      if (rsp_valid && rsp_ready && !err_q && (ops_q != '1)) ops_q <= ops_q + 1'b1;
      if (timeout_hit && (timeouts_q != '1))                 timeouts_q <= timeouts_q + 1'b1;
      if (drive_evt && (state_q != ST_WAIT) && (spurious_q != '1))
        spurious_q <= spurious_q + 1'b1;
    end
  end

  assign stat_ops      = ops_q;
  assign stat_timeouts = timeouts_q;
  assign stat_spurious = spurious_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
